// File: rtl/ntt_pkg.sv
// Shared constants for the NTT datapath: modulus, Barrett constant,
// butterfly latency and mode encodings.
package ntt_pkg;

    localparam int unsigned Q            = 8380417;
    localparam int unsigned QW           = 23;
    localparam int unsigned BARRETT_M    = 8396807;
    localparam int unsigned BFLY_LATENCY = 5;

    localparam logic MODE_CT = 1'b0;
    localparam logic MODE_GS = 1'b1;

endpackage

// File: rtl/ntt_butterfly_pipe_if.sv
// Butterfly operand/result bus. The master is the coefficient read stage,
// and the slave is the butterfly.
//
// Handshake: there is no ready. An op is accepted on a clk edge where
// valid_in=1 and en=1. A result is presented when valid_out=1. With en=0
// the whole pipeline, including valid_out, x and y, holds.
//
// Optional: NTT_BFLY_CHECK_EN adds the sticky err flag.
interface ntt_butterfly_pipe_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  en;
    logic                  valid_in;
    logic                  mode;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] w;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
`ifdef NTT_BFLY_CHECK_EN
    logic                  err;

    modport master (output en, valid_in, mode, a, b, w,
                    input  valid_out, x, y, err);
    modport slave  (input  en, valid_in, mode, a, b, w,
                    output valid_out, x, y, err);
`else
    modport master (output en, valid_in, mode, a, b, w,
                    input  valid_out, x, y);
    modport slave  (input  en, valid_in, mode, a, b, w,
                    output valid_out, x, y);
`endif
endinterface

// File: rtl/mod_mul_barrett.sv
// Three-stage modular multiplier, r = u*v mod Q, using Barrett reduction.
//   Stage 1: P = u*v
//   Stage 2: t = ((P >> (QW-1)) * BARRETT_M) >> (QW+1)
//   Stage 3: r = P - t*Q, which lies in [0,3Q). Two conditional subtracts
//            bring it into [0,Q).
// All stages advance only when en=1. rst clears every stage.
// Operands must be below Q.
module mod_mul_barrett
    import ntt_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] u,
    input  logic [W-1:0] v,
    output logic [W-1:0] r
);

    localparam logic [W+1:0] Q_R = (W+2)'(Q);

    logic [2*W-1:0] p_s2;
    logic [2*W-1:0] p_s3;
    logic [2*W-1:0] t_s3;
    logic [W-1:0]   r_s4;
    logic [2*W-1:0] t_c;
    logic [W+1:0]   r_raw;
    logic [W+1:0]   r_one;
    logic [W+1:0]   r_two;

    // Barrett quotient estimate from the stage-2 product.
    always_comb begin
        t_c = (2*W)'((((3*W)'(p_s2) >> (QW-1)) * (3*W)'(BARRETT_M)) >> (QW+1));
    end

    // Remainder correction. The true remainder fits well inside W+2 bits, so truncating the wide difference is exact.
    always_comb begin
        r_raw = (W+2)'(p_s3 - (2*W)'(t_s3 * (2*W)'(Q)));
        r_one = (r_raw >= Q_R) ? (r_raw - Q_R) : r_raw;
        r_two = (r_one >= Q_R) ? (r_one - Q_R) : r_one;
    end

    // Stage registers: product, estimate and reduced result.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_s2 <= '0;
            p_s3 <= '0;
            t_s3 <= '0;
            r_s4 <= '0;
        end else if (en) begin
            p_s2 <= (2*W)'(u) * (2*W)'(v);
            p_s3 <= p_s2;
            t_s3 <= t_c;
            r_s4 <= W'(r_two);
        end
    end

    assign r = r_s4;

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// Pipelined modular butterfly with a fixed latency of 5 enabled edges.
// Each op selects its mode: CT (forward) or GS (inverse).
//   CT: x = a + b*w,  y = a - b*w      (mod Q)
//   GS: x = a + b,    y = (a - b)*w    (mod Q)
// The S1 pre-add and the S5 post-add live here. S2-S4 are in
// mod_mul_barrett. The mode bit and the upper operand, or the GS sum,
// ride a side pipeline that stays aligned with the multiplier.
// Optional macro NTT_BFLY_CHECK_EN enables the sticky range-check flag err.
module ntt_butterfly_pipe
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    ntt_butterfly_pipe_if.slave   bus
);

    localparam int DW = DATA_WIDTH;
    localparam int NS = BFLY_LATENCY - 1;
    localparam logic [DW:0] Q_E = (DW+1)'(Q);

    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] u, input logic [DW-1:0] v);
        logic [DW:0] s;
        s = {1'b0, u} + {1'b0, v};
        if (s >= Q_E) s = s - Q_E;
        return DW'(s);
    endfunction

    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] u, input logic [DW-1:0] v);
        logic [DW:0] d;
        d = {1'b0, u} - {1'b0, v};
        if (d[DW]) d = d + Q_E;
        return DW'(d);
    endfunction

    logic [NS:1]   v_pipe;
    logic [NS:1]   m_pipe;
    logic [DW-1:0] u_pipe [1:NS];
    logic [DW-1:0] m1_s1;
    logic [DW-1:0] w_s1;
    logic [DW-1:0] r_s4;
    logic [DW-1:0] s1_u_c;
    logic [DW-1:0] s1_m1_c;
    logic [DW-1:0] x_c;
    logic [DW-1:0] y_c;

    // S1 pre-add. GS forms the sum (kept for x) and the difference (to be multiplied). CT passes a and b through.
    always_comb begin
        s1_u_c  = bus.a;
        s1_m1_c = bus.b;
        if (bus.mode == MODE_GS) begin
            s1_u_c  = mod_add(bus.a, bus.b);
            s1_m1_c = mod_sub(bus.a, bus.b);
        end
    end

    // S1 registers plus the valid/mode/upper-operand side pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
            m_pipe <= '0;
            m1_s1  <= '0;
            w_s1   <= '0;
            for (int i = 1; i <= NS; i++) u_pipe[i] <= '0;
        end else if (bus.en) begin
            v_pipe    <= {v_pipe[NS-1:1], bus.valid_in};
            m_pipe    <= {m_pipe[NS-1:1], bus.mode};
            m1_s1     <= s1_m1_c;
            w_s1      <= bus.w;
            u_pipe[1] <= s1_u_c;
            for (int i = 2; i <= NS; i++) u_pipe[i] <= u_pipe[i-1];
        end
    end

    // S2-S4: modular product of the S1 multiplicand and the twiddle.
    mod_mul_barrett #(
        .W (DW)
    ) u_mul (
        .clk (clk),
        .rst (rst),
        .en  (bus.en),
        .u   (m1_s1),
        .v   (w_s1),
        .r   (r_s4)
    );

    // S5 post-add. CT combines the upper operand with the product. GS emits the stored sum and the product.
    always_comb begin
        x_c = u_pipe[NS];
        y_c = r_s4;
        if (m_pipe[NS] == MODE_CT) begin
            x_c = mod_add(u_pipe[NS], r_s4);
            y_c = mod_sub(u_pipe[NS], r_s4);
        end
    end

    // Output register. x and y load only on a valid op, so they hold through bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_out <= 1'b0;
            bus.x         <= '0;
            bus.y         <= '0;
        end else if (bus.en) begin
            bus.valid_out <= v_pipe[NS];
            if (v_pipe[NS]) begin
                bus.x <= x_c;
                bus.y <= y_c;
            end
        end
    end

`ifdef NTT_BFLY_CHECK_EN
    localparam logic [DW-1:0] Q_D = DW'(Q);

    // Sticky range check on accepted operands. Only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.err <= 1'b0;
        end else if (bus.en && bus.valid_in &&
                     (bus.a >= Q_D || bus.b >= Q_D || bus.w >= Q_D)) begin
            bus.err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Directed bench for ntt_butterfly_pipe. It covers reset values,
// hand-computed CT/GS vectors, modular wrap boundaries, a mixed-mode
// stream with a stalling en against an arithmetic reference, reset with
// ops in flight, and (with NTT_BFLY_CHECK_EN) the sticky err flag.
module tb_ntt_butterfly_pipe;

    localparam int unsigned QM = 8380417;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [63:0] exp_q[$];

    ntt_butterfly_pipe_if #(.DATA_WIDTH(24)) bus ();

    ntt_butterfly_pipe #(.DATA_WIDTH(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference butterfly using plain % arithmetic.
    task automatic model(input logic mode, input longint unsigned a, input longint unsigned b,
                         input longint unsigned w, output logic [23:0] x, output logic [23:0] y);
        longint unsigned p;
        longint unsigned d;
        if (mode == 1'b0) begin
            p = (b * w) % QM;
            x = 24'((a + p) % QM);
            y = 24'((a + QM - p) % QM);
        end else begin
            d = (a + QM - b) % QM;
            x = 24'((a + b) % QM);
            y = 24'((d * w) % QM);
        end
    endtask

    function automatic logic [23:0] pick();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 24'd0;
        if (r == 1) return 24'(QM - 1);
        return 24'($urandom_range(0, QM - 1));
    endfunction

    // Single op with en held high: valid_out must stay low for 4 edges and rise on the 5th.
    task automatic run_op(input string tag, input logic mode, input logic [23:0] a,
                          input logic [23:0] b, input logic [23:0] w,
                          input logic [23:0] ex, input logic [23:0] ey);
        bus.en = 1'b1;
        bus.valid_in = 1'b1;
        bus.mode = mode;
        bus.a = a;
        bus.b = b;
        bus.w = w;
        for (int i = 1; i <= 4; i++) begin
            step();
            bus.valid_in = 1'b0;
            check({tag, "_early"}, 32'(bus.valid_out), 32'd0);
        end
        step();
        check({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
        check({tag, "_x"}, 32'(bus.x), 32'(ex));
        check({tag, "_y"}, 32'(bus.y), 32'(ey));
    endtask

    initial begin
        logic [23:0] ex;
        logic [23:0] ey;
        logic [23:0] last_x;
        logic [63:0] ent;
        logic        en_d;
        int          en_edges;
        int          sent;

        bus.en = 1'b1;
        bus.valid_in = 1'b0;
        bus.mode = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.w = '0;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        check("rst_x", 32'(bus.x), 32'd0);
        check("rst_y", 32'(bus.y), 32'd0);
`ifdef NTT_BFLY_CHECK_EN
        check("rst_err", 32'(bus.err), 32'd0);
`endif

        // Directed vectors
        run_op("ct_basic", 1'b0, 24'd1, 24'd2, 24'd3, 24'd7, 24'd8380412);
        run_op("gs_basic", 1'b1, 24'd5, 24'd3, 24'd2, 24'd8, 24'd4);
        run_op("gs_neg", 1'b1, 24'd1, 24'd2, 24'd1, 24'd3, 24'd8380416);
        run_op("ct_wrap_hi", 1'b0, 24'd8380416, 24'd1, 24'd1, 24'd0, 24'd8380415);
        run_op("ct_max_mul", 1'b0, 24'd0, 24'd8380416, 24'd8380416, 24'd1, 24'd8380416);
        run_op("ct_bw_zero", 1'b0, 24'd12345, 24'd0, 24'd999, 24'd12345, 24'd12345);
        run_op("gs_a_eq_b", 1'b1, 24'd777, 24'd777, 24'd5000, 24'd1554, 24'd0);
        run_op("gs_max", 1'b1, 24'd8380416, 24'd8380416, 24'd8380416, 24'd8380415, 24'd0);

        // Bubbles: x and y hold while valid_out is low
        step();
        step();
        check("hold_valid", 32'(bus.valid_out), 32'd0);
        check("hold_x", 32'(bus.x), 32'd8380415);
        check("hold_y", 32'(bus.y), 32'd0);

        // Mixed-mode stream with en about 30% low
        en_edges = 0;
        sent = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (sent >= 100 && exp_q.size() == 0) break;
            if (sent < 100) begin
                bus.en = ($urandom_range(0, 9) >= 3);
                bus.valid_in = 1'b1;
                bus.mode = 1'($urandom_range(0, 1));
                bus.a = pick();
                bus.b = pick();
                bus.w = pick();
            end else begin
                bus.en = 1'b1;
                bus.valid_in = 1'b0;
            end
            if (bus.en && bus.valid_in) begin
                model(bus.mode, 64'(bus.a), 64'(bus.b), 64'(bus.w), ex, ey);
                exp_q.push_back({16'(en_edges + 5), ex, ey});
                sent++;
            end
            en_d = bus.en;
            step();
            if (en_d) en_edges++;
            if (en_d && bus.valid_out) begin
                check("stream_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    ent = exp_q.pop_front();
                    check("stream_latency", 32'(en_edges), 32'(ent[63:48]));
                    check("stream_x", 32'(bus.x), 32'(ent[47:24]));
                    check("stream_y", 32'(bus.y), 32'(ent[23:0]));
                end
            end
        end
        check("stream_drain", 32'(exp_q.size()), 32'd0);
        check("stream_sent", 32'(sent), 32'd100);
`ifdef NTT_BFLY_CHECK_EN
        check("stream_err", 32'(bus.err), 32'd0);
`endif

        // Reset with 3 ops in flight; rst wins over en=0
        bus.en = 1'b1;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.mode = 1'(i);
            bus.a = 24'(1000 + i);
            bus.b = 24'(7 + i);
            bus.w = 24'(3 + i);
            step();
        end
        last_x = bus.x;
        bus.valid_in = 1'b0;
        bus.en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.en = 1'b1;
        check("inflight_rst_valid", 32'(bus.valid_out), 32'd0);
        check("inflight_rst_x", 32'(bus.x), 32'd0);
        check("inflight_rst_y", 32'(bus.y), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_stale", 32'(bus.valid_out), 32'd0);
        end
        run_op("post_rst", 1'b0, 24'd100, 24'd200, 24'd300, 24'd60100, 24'd8320517);
        if (last_x == 24'd0) $display("note: x was zero before the in-flight reset");

`ifdef NTT_BFLY_CHECK_EN
        // An out-of-range operand without valid_in is ignored
        bus.en = 1'b1;
        bus.valid_in = 1'b0;
        bus.a = 24'd8380417;
        bus.b = 24'd0;
        bus.w = 24'd0;
        step();
        check("err_no_valid", 32'(bus.err), 32'd0);
        // An accepted out-of-range operand sets err, and err stays set
        bus.valid_in = 1'b1;
        step();
        bus.valid_in = 1'b0;
        bus.a = 24'd1;
        check("err_set", 32'(bus.err), 32'd1);
        for (int i = 0; i < 3; i++) step();
        check("err_sticky", 32'(bus.err), 32'd1);
        bus.en = 1'b0;
        step();
        check("err_sticky_stall", 32'(bus.err), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.en = 1'b1;
        check("err_rst", 32'(bus.err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
